dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, loader and byte-memory signals around dmem_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              core_req;
  logic              core_we;
  logic [2:0]        core_funct3;
  logic [31:0]       core_addr;
  logic [31:0]       core_wdata;
  logic              core_done;
  logic              core_err;
  logic [31:0]       core_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [31:0]       ldr_addr;
  logic [31:0]       ldr_wdata;
  logic              ldr_done;
  logic [31:0]       ldr_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic              busy;

  modport slave (
    input  core_req, core_we, core_funct3, core_addr, core_wdata,
    output core_done, core_err, core_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_done, ldr_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output core_req, core_we, core_funct3, core_addr, core_wdata,
    input  core_done, core_err, core_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_done, ldr_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between core and loader onto a byte-wide synchronous-read data memory.
// Multi-byte accesses are split into little-endian byte cycles; loads are extended per funct3.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 10
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;  // 1 = loader
  logic              last_q, last_d;    // 1 = loader was granted last
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;
  logic [31:0]       core_rdata_q, core_rdata_d;
  logic [31:0]       ldr_rdata_q, ldr_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic              sel_ldr;
  logic              sel_we;
  logic [2:0]        sel_funct3;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_legal;
  logic [1:0]        last_idx;
  logic [1:0]        idx_nxt;
  logic [1:0]        idx_prev;
  logic              unused_addr;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] r);
    unique case (f3)
      3'b000:  extend = {{24{r[7]}}, r[7:0]};
      3'b001:  extend = {{16{r[15]}}, r[15:0]};
      3'b100:  extend = {24'h0, r[7:0]};
      3'b101:  extend = {16'h0, r[15:0]};
      default: extend = r;
    endcase
  endfunction

  always_comb begin
    // Alternate on contention; last_q resets to loader so the core wins first.
    sel_ldr    = bus.ldr_req && (!bus.core_req || !last_q);
    sel_we     = sel_ldr ? bus.ldr_we    : bus.core_we;
    sel_funct3 = sel_ldr ? 3'b010        : bus.core_funct3;
    sel_addr   = sel_ldr ? bus.ldr_addr  : bus.core_addr;
    sel_wdata  = sel_ldr ? bus.ldr_wdata : bus.core_wdata;
    sel_legal  = sel_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  assign unused_addr = ^sel_addr[31:ADDR_W];

  // Index of the final byte: 0 for B/BU, 1 for H/HU, 3 for W.
  assign last_idx = funct3_q[1] ? 2'd3 : (funct3_q[0] ? 2'd1 : 2'd0);
  assign idx_nxt  = idx_q + 2'd1;
  assign idx_prev = idx_q - 2'd1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    result_d     = result_q;
    err_d        = err_q;
    core_rdata_d = core_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.core_req || bus.ldr_req) begin
          grant_d  = sel_ldr;
          last_d   = sel_ldr;
          we_d     = sel_we;
          funct3_d = sel_funct3;
          wdata_d  = sel_wdata;
          idx_d    = 2'd0;
          result_d = 32'h0;
          err_d    = !sel_legal;
          if (!sel_legal) begin
            state_d = StDone;
          end else begin
            state_d     = StAccess;
            mem_addr_d  = sel_addr[ADDR_W-1:0];
            mem_we_d    = sel_we;
            mem_wdata_d = sel_we ? sel_wdata[7:0] : 8'h00;
          end
        end
      end

      StAccess: begin
        // Read data lags its address by one cycle, so capture the previous byte.
        if (!we_q && idx_q != 2'd0) begin
          result_d[{idx_prev, 3'b000} +: 8] = bus.mem_rdata;
        end
        if (idx_q == last_idx) begin
          mem_we_d    = 1'b0;
          mem_wdata_d = 8'h00;
          state_d     = we_q ? StDone : StDrain;
        end else begin
          idx_d       = idx_nxt;
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
          mem_wdata_d = we_q ? wdata_q[{idx_nxt, 3'b000} +: 8] : 8'h00;
        end
      end

      StDrain: begin
        result_d[{last_idx, 3'b000} +: 8] = bus.mem_rdata;
        if (grant_q) begin
          ldr_rdata_d = result_d;
        end else begin
          core_rdata_d = extend(funct3_q, result_d);
        end
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      wdata_q      <= 32'h0;
      idx_q        <= 2'd0;
      result_q     <= 32'h0;
      err_q        <= 1'b0;
      core_rdata_q <= 32'h0;
      ldr_rdata_q  <= 32'h0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      result_q     <= result_d;
      err_q        <= err_d;
      core_rdata_q <= core_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.core_done  = (state_q == StDone) && !grant_q;
  assign bus.ldr_done   = (state_q == StDone) && grant_q;
  assign bus.core_err   = bus.core_done && err_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.ldr_rdata  = ldr_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  // A reset arriving mid-write must stop the byte on the same edge.
  assign bus.mem_we     = mem_we_q && !rst;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases plus random accesses against a byte-array reference.
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned MEM_SIZE = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0]        mem     [MEM_SIZE];
  logic [7:0]        ref_mem [MEM_SIZE];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_data = 8'h00;

  // Byte memory with synchronous read; pre_* is the bench's back door for initial contents.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_core_rdata = 32'h0;
  logic [31:0] exp_ldr_rdata  = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int unsigned a, input logic [7:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = ADDR_W'(a);
    pre_data = d;
    ref_mem[a % MEM_SIZE] = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // One transaction on one port; DUT must be idle on entry.
  task automatic access(input bit port, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic [2:0]  eff_f3;
    bit          legal;
    int          n;
    int          exp_cyc;
    logic [31:0] raw;
    int unsigned a;
    eff_f3 = port ? 3'b010 : f3;
    legal  = eff_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (eff_f3)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      default:        n = 4;
    endcase
    if (!legal) n = 0;
    exp_cyc = !legal ? 1 : (we ? n + 1 : n + 2);

    raw = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = (addr + 32'(i)) % MEM_SIZE;
      if (we) ref_mem[a] = wdata[8*i +: 8];
      else    raw = raw | (32'(ref_mem[a]) << (8 * i));
    end
    if (legal && !we) begin
      if (eff_f3 == 3'b000 && raw >= 32'd128)   raw = raw - 32'd256;
      if (eff_f3 == 3'b001 && raw >= 32'd32768) raw = raw - 32'd65536;
      if (port) exp_ldr_rdata = raw;
      else      exp_core_rdata = raw;
    end

    @(negedge clk);
    if (port) begin
      bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
    end else begin
      bus.core_req = 1'b1; bus.core_we = we; bus.core_funct3 = f3;
      bus.core_addr = addr; bus.core_wdata = wdata;
    end
    @(posedge clk);
    for (int k = 1; k <= exp_cyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Granted request must be latched; disturb the live inputs.
        bus.core_we = 1'($urandom); bus.core_funct3 = 3'($urandom);
        bus.core_addr = $urandom; bus.core_wdata = $urandom;
        bus.ldr_we = 1'($urandom); bus.ldr_addr = $urandom; bus.ldr_wdata = $urandom;
      end
      if (k <= n) begin
        check({tag, "_addr"}, 32'(bus.mem_addr), (addr + 32'(k - 1)) % MEM_SIZE);
        check({tag, "_we"}, 32'(bus.mem_we), 32'(we));
      end else begin
        check({tag, "_we_idle"}, 32'(bus.mem_we), 32'h0);
      end
      check({tag, "_busy"}, 32'(bus.busy), 32'h1);
      check({tag, "_done"}, 32'(port ? bus.ldr_done : bus.core_done), 32'(k == exp_cyc));
      check({tag, "_other_done"}, 32'(port ? bus.core_done : bus.ldr_done), 32'h0);
    end
    if (port) begin
      check({tag, "_ldr_rdata"}, bus.ldr_rdata, exp_ldr_rdata);
    end else begin
      check({tag, "_core_rdata"}, bus.core_rdata, exp_core_rdata);
      check({tag, "_core_err"}, 32'(bus.core_err), 32'(!legal));
    end
    bus.core_req = 1'b0;
    bus.ldr_req  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          order[4];
    int          cnt;
    int          nbad;
    bit          port;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;

    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_funct3 = 3'b000;
    bus.core_addr = 32'h0; bus.core_wdata = 32'h0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = 32'h0; bus.ldr_wdata = 32'h0;
    rst = 1'b1;

    for (int a = 0; a < int'(MEM_SIZE); a++) preload(a, 8'($urandom));
    preload(32'h20, 8'h80);
    preload(32'h3FF, 8'h34);
    preload(32'h000, 8'h92);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_core_done", 32'(bus.core_done), 32'h0);
    check("rst_core_err", 32'(bus.core_err), 32'h0);
    check("rst_ldr_done", 32'(bus.ldr_done), 32'h0);
    check("rst_core_rdata", bus.core_rdata, 32'h0);
    check("rst_ldr_rdata", bus.ldr_rdata, 32'h0);

    access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw");
    check("sw_b0", 32'(mem[10'h10]), 32'hEF);
    check("sw_b1", 32'(mem[10'h11]), 32'hBE);
    check("sw_b2", 32'(mem[10'h12]), 32'hAD);
    check("sw_b3", 32'(mem[10'h13]), 32'hDE);
    access(1'b0, 1'b0, 3'b000, 32'h20, 32'h0, "lb");
    check("lb_val", bus.core_rdata, 32'hFFFFFF80);
    access(1'b0, 1'b0, 3'b100, 32'h20, 32'h0, "lbu");
    check("lbu_val", bus.core_rdata, 32'h00000080);
    access(1'b0, 1'b0, 3'b001, 32'h3FF, 32'h0, "lh_wrap");
    check("lh_wrap_val", bus.core_rdata, 32'hFFFF9234);
    access(1'b0, 1'b0, 3'b011, 32'h40, 32'h0, "illegal");
    check("illegal_keep", bus.core_rdata, 32'hFFFF9234);
    access(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, "ldr_lw");
    check("ldr_lw_val", bus.ldr_rdata, 32'hDEADBEEF);

    for (int t = 0; t < 80; t++) begin
      port = 1'($urandom);
      we   = 1'($urandom);
      f3   = 3'($urandom);
      if (!port && $urandom_range(0, 7) != 0 && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
        f3 = 3'b010;
      addr = $urandom;
      if ($urandom_range(0, 3) == 0) addr = {addr[31:10], 8'hFF, 2'($urandom)};
      access(port, we, f3, addr, $urandom, "rand");
    end

    // Contention: both requesters held high must alternate starting with the core.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_core_rdata = 32'h0;
    exp_ldr_rdata  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ref_mem[32'h200 + i] = 8'(32'hA5A55A5A >> (8 * i));
      ref_mem[32'h300 + i] = 8'(32'h0BADF00D >> (8 * i));
    end
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_funct3 = 3'b010;
    bus.core_addr = 32'h200; bus.core_wdata = 32'hA5A55A5A;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 32'h300; bus.ldr_wdata = 32'h0BADF00D;
    cnt = 0;
    for (int c = 0; c < 60 && cnt < 4; c++) begin
      @(negedge clk);
      if (bus.core_done && bus.ldr_done) check("rr_both_done", 32'h1, 32'h0);
      if (bus.core_done || bus.ldr_done) begin
        order[cnt] = int'(bus.ldr_done);
        cnt++;
        if (cnt == 4) begin
          bus.core_req = 1'b0;
          bus.ldr_req  = 1'b0;
        end
      end
    end
    bus.core_req = 1'b0;
    bus.ldr_req  = 1'b0;
    check("rr_count", 32'(cnt), 32'd4);
    for (int i = 0; i < cnt && i < 4; i++) check("rr_order", 32'(order[i]), 32'(i % 2));
    @(negedge clk);
    @(negedge clk);
    check("rr_idle", 32'(bus.busy), 32'h0);

    // Reset during the third byte of a store.
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_funct3 = 3'b010;
    bus.core_addr = 32'h50; bus.core_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_addr", 32'(bus.mem_addr), 32'h52);
    check("rstmid_we", 32'(bus.mem_we), 32'h1);
    rst = 1'b1;
    bus.core_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_busy", 32'(bus.busy), 32'h0);
    check("rstmid_mem_we", 32'(bus.mem_we), 32'h0);
    check("rstmid_done", 32'(bus.core_done), 32'h0);
    rst = 1'b0;
    exp_core_rdata = 32'h0;
    exp_ldr_rdata  = 32'h0;
    ref_mem[32'h50] = 8'h44;
    ref_mem[32'h51] = 8'h33;
    check("rstmid_b2", 32'(mem[10'h52]), 32'(ref_mem[32'h52]));
    check("rstmid_b3", 32'(mem[10'h53]), 32'(ref_mem[32'h53]));
    @(negedge clk);
    check("rstmid_no_done", 32'(bus.core_done), 32'h0);
    access(1'b0, 1'b0, 3'b010, 32'h50, 32'h0, "post_rst_lw");

    nbad = 0;
    for (int a = 0; a < int'(MEM_SIZE); a++) if (mem[a] !== ref_mem[a]) nbad++;
    check("mem_image", 32'(nbad), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
